// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath widths, the nop encoding, the IF/ID
// register layout and the fetch FSM state type.
package riscv_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INSTR  = 32'b0;
    localparam int          INST_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    typedef enum logic {FETCH_RUN, FETCH_HALT} fetch_state_t;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC / IF/ID priority mux for the fetch stage (purely combinational).
// Ports:
//   state        in   current fetch FSM state
//   pc_q         in   current PC
//   stall        in   hazard-unit hold request
//   redirect     in   EX branch/jump redirect
//   redirect_pc  in   redirect target (low two bits ignored)
//   pc_d         out  next PC value
//   ifid_load    out  IF/ID register load enable
//   ifid_bubble  out  load a bubble instead of the fetched word
//   count_en     out  a real instruction enters IF/ID this cycle
//   fault        out  current PC is past the end of instruction memory
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_INST = 128
) (
    input  fetch_state_t    state,
    input  logic [XLEN-1:0] pc_q,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_d,
    output logic            ifid_load,
    output logic            ifid_bubble,
    output logic            count_en,
    output logic            fault
);

    logic out_of_range;
    assign out_of_range = ({2'b00, pc_q[XLEN-1:2]} >= NUM_INST);

    // Redirect outranks stall so a held wrong-path instruction is flushed.
    always_comb begin
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        count_en    = 1'b0;
        fault       = 1'b0;
        if (redirect) begin
            pc_d        = align_pc(redirect_pc);
            ifid_load   = 1'b1;
            ifid_bubble = 1'b1;
        end else if (state == FETCH_RUN) begin
            if (out_of_range) begin
                ifid_load   = 1'b1;
                ifid_bubble = 1'b1;
                fault       = 1'b1;
            end else if (!stall) begin
                pc_d      = pc_q + XLEN'(INST_BYTES);
                ifid_load = 1'b1;
                count_en  = 1'b1;
            end
        end else if (!stall) begin
            ifid_load   = 1'b1;
            ifid_bubble = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the combinational instruction memory and
// captures the returned word into the IF/ID register. Handles decode stalls,
// EX redirects and halts when fetching past the end of the program.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   imem_pc        instruction memory address (= pc_q)
//   imem_instr     instruction word for imem_pc
//   stall          hold PC and IF/ID
//   redirect       flush IF/ID and load redirect_pc
//   redirect_pc    redirect target
//   if_id_pc       PC of the instruction in IF/ID
//   if_id_instr    instruction in IF/ID (0 for a bubble)
//   if_id_valid    IF/ID holds a real fetched instruction
//   halted         fetch halted after an out-of-range PC
//   fetch_count    number of valid instructions loaded into IF/ID
//
// state      | meaning
// FETCH_RUN  | normal fetch: redirect > fault > stall > advance
// FETCH_HALT | PC past program end; bubbles issued until redirect or reset
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_INST = 128
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    if_id_t       if_id_q;
    logic [31:0]  count_q;
    logic         ifid_load, ifid_bubble, count_en, fault;

    pc_next_sel #(.NUM_INST(NUM_INST)) u_pc_next_sel (
        .state       (state_q),
        .pc_q        (pc_q),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_d        (pc_d),
        .ifid_load   (ifid_load),
        .ifid_bubble (ifid_bubble),
        .count_en    (count_en),
        .fault       (fault)
    );

    always_comb begin
        state_d = state_q;
        if (redirect)
            state_d = FETCH_RUN;
        else if (fault)
            state_d = FETCH_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
            if_id_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ifid_load) begin
                if (ifid_bubble)
                    if_id_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
                else
                    if_id_q <= '{pc: pc_q, instr: imem_instr, valid: 1'b1};
            end
            if (count_en)
                count_q <= count_q + 32'd1;
        end
    end

    assign imem_pc     = pc_q;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;
    assign halted      = (state_q == FETCH_HALT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] salt = 32'h0;
    logic [31:0] zero_pc = 32'h1;

    logic [31:0] o_imem_pc [3];
    logic [31:0] o_instr_in[3];
    logic [31:0] o_ip      [3];
    logic [31:0] o_ii      [3];
    logic [31:0] o_cnt     [3];
    logic        o_iv      [3];
    logic        o_h       [3];

    int n_checks = 0;
    int n_errors = 0;

    // Instruction memory image: word i holds 0x100+i (xor salt); one chosen
    // address returns an all-zero word.
    function automatic logic [31:0] memf(input logic [31:0] pc, input logic [31:0] s,
                                         input logic [31:0] zp);
        if (pc == zp) return 32'h0;
        return (32'h100 + (pc >> 2)) ^ s;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_mem
        assign o_instr_in[k] = memf(o_imem_pc[k], salt, zero_pc);
    end

    fetch_stage #(.RESET_PC(32'h0), .NUM_INST(128)) dut0 (
        .clk(clk), .rst(rst), .imem_pc(o_imem_pc[0]), .imem_instr(o_instr_in[0]),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_pc(o_ip[0]), .if_id_instr(o_ii[0]), .if_id_valid(o_iv[0]),
        .halted(o_h[0]), .fetch_count(o_cnt[0]));

    fetch_stage #(.RESET_PC(32'h0), .NUM_INST(16)) dut1 (
        .clk(clk), .rst(rst), .imem_pc(o_imem_pc[1]), .imem_instr(o_instr_in[1]),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_pc(o_ip[1]), .if_id_instr(o_ii[1]), .if_id_valid(o_iv[1]),
        .halted(o_h[1]), .fetch_count(o_cnt[1]));

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NUM_INST(32'h4000_0000)) dut2 (
        .clk(clk), .rst(rst), .imem_pc(o_imem_pc[2]), .imem_instr(o_instr_in[2]),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_pc(o_ip[2]), .if_id_instr(o_ii[2]), .if_id_valid(o_iv[2]),
        .halted(o_h[2]), .fetch_count(o_cnt[2]));

    // Reference model: architectural state of each fetch unit.
    logic [31:0] p_rpc[3] = '{32'h0, 32'h0, 32'hFFFF_FFF8};
    longint      p_n  [3] = '{128, 16, 64'h4000_0000};
    logic [31:0] m_pc [3];
    logic [31:0] m_ip [3];
    logic [31:0] m_ii [3];
    logic [31:0] m_cnt[3];
    logic        m_iv [3];
    logic        m_h  [3];

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        rst = r; stall = s; redirect = d; redirect_pc = t;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_pc[k] = p_rpc[k]; m_ip[k] = 0; m_ii[k] = 0; m_iv[k] = 0;
                m_h[k] = 0; m_cnt[k] = 0;
            end else if (d) begin
                m_pc[k] = t & 32'hFFFF_FFFC;
                m_ip[k] = 0; m_ii[k] = 0; m_iv[k] = 0; m_h[k] = 0;
            end else if (m_h[k]) begin
                if (!s) begin m_ip[k] = 0; m_ii[k] = 0; m_iv[k] = 0; end
            end else if (longint'(m_pc[k] / 4) >= p_n[k]) begin
                m_ip[k] = 0; m_ii[k] = 0; m_iv[k] = 0; m_h[k] = 1;
            end else if (!s) begin
                m_ip[k] = m_pc[k];
                m_ii[k] = memf(m_pc[k], salt, zero_pc);
                m_iv[k] = 1;
                m_pc[k] = m_pc[k] + 4;
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_imem_pc[k] !== p_rpc[k] || o_ip[k] !== 32'h0 || o_ii[k] !== 32'h0 ||
                o_iv[k] !== 1'b0 || o_h[k] !== 1'b0 || o_cnt[k] !== 32'h0) begin
                n_errors++;
                $display("FAIL reset dut%0d: got pc=%h ip=%h ii=%h v=%b h=%b cnt=%0d, want pc=%h rest zero",
                         k, o_imem_pc[k], o_ip[k], o_ii[k], o_iv[k], o_h[k], o_cnt[k], p_rpc[k]);
            end
        end
    endtask

    task automatic test_run();
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (o_ip[0] !== 32'(4 * i) || o_ii[0] !== 32'(32'h100 + i) || o_iv[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL run%0d: got ip=%h ii=%h v=%b, want ip=%h ii=%h v=1",
                         i, o_ip[0], o_ii[0], o_iv[0], 4 * i, 32'h100 + i);
            end
        end
        n_checks++;
        if (o_cnt[0] !== 32'd4) begin
            n_errors++;
            $display("FAIL run_count: got %0d want 4", o_cnt[0]);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (o_imem_pc[0] !== 32'h8 || o_ip[0] !== 32'h4 || o_cnt[0] !== 32'd2) begin
                n_errors++;
                $display("FAIL stall%0d: got pc=%h ip=%h cnt=%0d, want pc=8 ip=4 cnt=2",
                         i, o_imem_pc[0], o_ip[0], o_cnt[0]);
            end
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (o_ip[0] !== 32'h8 || o_ii[0] !== 32'h102 || o_cnt[0] !== 32'd3) begin
            n_errors++;
            $display("FAIL stall_release: got ip=%h ii=%h cnt=%0d, want ip=8 ii=102 cnt=3",
                     o_ip[0], o_ii[0], o_cnt[0]);
        end
    endtask

    task automatic test_redirect();
        step(0, 1, 1, 32'h0000_0043);
        n_checks++;
        if (o_imem_pc[0] !== 32'h40 || o_iv[0] !== 1'b0 || o_ii[0] !== 32'h0 || o_cnt[0] !== 32'd3) begin
            n_errors++;
            $display("FAIL redirect: got pc=%h v=%b ii=%h cnt=%0d, want pc=40 v=0 ii=0 cnt=3",
                     o_imem_pc[0], o_iv[0], o_ii[0], o_cnt[0]);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (o_ip[0] !== 32'h40 || o_ii[0] !== 32'h110 || o_iv[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL redirect_fetch: got ip=%h ii=%h v=%b, want ip=40 ii=110 v=1",
                     o_ip[0], o_ii[0], o_iv[0]);
        end
    endtask

    task automatic test_halt();
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0);
        n_checks++;
        if (o_ip[1] !== 32'h3C || o_cnt[1] !== 32'd16 || o_h[1] !== 1'b0 || o_imem_pc[1] !== 32'h40) begin
            n_errors++;
            $display("FAIL halt_last: got ip=%h cnt=%0d h=%b pc=%h, want ip=3c cnt=16 h=0 pc=40",
                     o_ip[1], o_cnt[1], o_h[1], o_imem_pc[1]);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (o_h[1] !== 1'b1 || o_iv[1] !== 1'b0 || o_imem_pc[1] !== 32'h40 || o_cnt[1] !== 32'd16) begin
                n_errors++;
                $display("FAIL halt%0d: got h=%b v=%b pc=%h cnt=%0d, want h=1 v=0 pc=40 cnt=16",
                         i, o_h[1], o_iv[1], o_imem_pc[1], o_cnt[1]);
            end
        end
        step(0, 0, 1, 32'h8);
        n_checks++;
        if (o_h[1] !== 1'b0 || o_imem_pc[1] !== 32'h8 || o_iv[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_exit: got h=%b pc=%h v=%b, want h=0 pc=8 v=0", o_h[1], o_imem_pc[1], o_iv[1]);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (o_ip[1] !== 32'h8 || o_ii[1] !== 32'h102 || o_iv[1] !== 1'b1 || o_cnt[1] !== 32'd17) begin
            n_errors++;
            $display("FAIL halt_resume: got ip=%h ii=%h v=%b cnt=%0d, want ip=8 ii=102 v=1 cnt=17",
                     o_ip[1], o_ii[1], o_iv[1], o_cnt[1]);
        end
    endtask

    task automatic test_zero_word();
        zero_pc = 32'h4;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_checks++;
        if (o_ip[0] !== 32'h4 || o_ii[0] !== 32'h0 || o_iv[0] !== 1'b1 || o_cnt[0] !== 32'd2) begin
            n_errors++;
            $display("FAIL zero_word: got ip=%h ii=%h v=%b cnt=%0d, want ip=4 ii=0 v=1 cnt=2",
                     o_ip[0], o_ii[0], o_iv[0], o_cnt[0]);
        end
        zero_pc = 32'h1;
    endtask

    task automatic test_reset_priority();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 1, 1, 32'h80);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_imem_pc[k] !== p_rpc[k] || o_ip[k] !== 32'h0 || o_ii[k] !== 32'h0 ||
                o_iv[k] !== 1'b0 || o_h[k] !== 1'b0 || o_cnt[k] !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_prio dut%0d: got pc=%h ip=%h ii=%h v=%b h=%b cnt=%0d, want pc=%h rest zero",
                         k, o_imem_pc[k], o_ip[k], o_ii[k], o_iv[k], o_h[k], o_cnt[k], p_rpc[k]);
            end
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0);
        n_checks++;
        if (o_imem_pc[2] !== 32'hFFFF_FFF8) begin
            n_errors++;
            $display("FAIL wrap_reset: got pc=%h want fffffff8", o_imem_pc[2]);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (o_imem_pc[2] !== 32'hFFFF_FFFC || o_ip[2] !== 32'hFFFF_FFF8 || o_h[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_1: got pc=%h ip=%h h=%b, want pc=fffffffc ip=fffffff8 h=0",
                     o_imem_pc[2], o_ip[2], o_h[2]);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (o_imem_pc[2] !== 32'h0 || o_ip[2] !== 32'hFFFF_FFFC || o_h[2] !== 1'b0 || o_iv[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_2: got pc=%h ip=%h h=%b v=%b, want pc=0 ip=fffffffc h=0 v=1",
                     o_imem_pc[2], o_ip[2], o_h[2], o_iv[2]);
        end
    endtask

    task automatic test_random();
        logic r, s, d;
        logic [31:0] t;
        salt = $urandom;
        zero_pc = 32'h18;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 99) < 30);
            d = ($urandom_range(0, 99) < 12);
            t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 767));
            step(r, s, d, t);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (o_imem_pc[k] !== m_pc[k] || o_ip[k] !== m_ip[k] || o_ii[k] !== m_ii[k] ||
                    o_iv[k] !== m_iv[k] || o_h[k] !== m_h[k] || o_cnt[k] !== m_cnt[k]) begin
                    n_errors++;
                    $display("FAIL rand%0d dut%0d: got pc=%h ip=%h ii=%h v=%b h=%b cnt=%0d, want pc=%h ip=%h ii=%h v=%b h=%b cnt=%0d",
                             i, k, o_imem_pc[k], o_ip[k], o_ii[k], o_iv[k], o_h[k], o_cnt[k],
                             m_pc[k], m_ip[k], m_ii[k], m_iv[k], m_h[k], m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_halt();
        test_zero_word();
        test_reset_priority();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
